// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage: instruction width, the
//   canonical NOP, the default reset PC and the RUN/DISCARD state encoding.
//   No ports.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO used by the fetch stage for the in-flight PC queue
//   and for the returned {pc, instr} buffer.
//   Ports:
//     clk, rst        clock, synchronous active-low reset
//     clear           drop all entries (dominates push/pop)
//     push, push_data write an entry (accepted when not full, or full with pop)
//     pop             remove the head entry (ignored when empty)
//     head            head entry, valid only when !empty
//     count           number of stored entries
//     full, empty     occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (rst && !clear && do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule : fetch_fifo

// File: rtl/fetch_stage_chk.sv
// -----------------------------------------------------------------------------
// fetch_stage_chk
//   Assertion checker for the fetch stage queues: neither the PC queue nor the
//   response buffer may ever be pushed while full without a matching pop.
//   Ports: clk, rst and the push/pop/full/clear strobes of both queues.
// -----------------------------------------------------------------------------
module fetch_stage_chk (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic buf_push,
  input logic buf_pop,
  input logic buf_full,
  input logic pcq_push,
  input logic pcq_pop,
  input logic pcq_full
);

  buf_no_overflow: assert property (@(posedge clk) disable iff (!rst || clear)
    !(buf_push && buf_full && !buf_pop));

  pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst || clear)
    !(pcq_push && pcq_full && !pcq_pop));

endmodule : fetch_stage_chk

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: PC generation, valid/ready instruction-memory
//   requests, in-order response buffering and the IF/ID pipeline register.
//   After a redirect, responses still in flight are discarded (DISCARD state).
//   Optional feature macro: FETCH_STATS_EN adds stat_fetched / stat_stalled.
//   Ports:
//     clk, rst                       clock, synchronous active-low reset
//     pc_stall                       suppress new requests
//     if_id_stall, flush             hold / invalidate the IF/ID register
//     redirect_valid, redirect_pc    taken branch/jump target (word aligned here)
//     imem_req_valid/ready/addr      request channel
//     imem_resp_valid/data           in-order response channel, always accepted
//     if_id_valid/pc/instr           IF/ID register towards decode
//     stat_fetched, stat_stalled     (FETCH_STATS_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                   BUS_WIDTH = 64,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(RESET_PC_DEFAULT),
  parameter int                   BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_stall,
  input  logic                   if_id_stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [BUS_WIDTH-1:0]   imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  output logic                   if_id_valid,
  output logic [BUS_WIDTH-1:0]   if_id_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [63:0]            stat_fetched,
  output logic [63:0]            stat_stalled
`endif
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = BUS_WIDTH + INSTR_WIDTH;
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  fetch_state_e         state_r;
  fetch_state_e         state_next_s;
  logic [CNT_W-1:0]     drop_cnt_r;
  logic [CNT_W-1:0]     drop_next_s;
  logic [CNT_W-1:0]     outstanding_s;
  logic [BUS_WIDTH-1:0] pc_r;

  logic                 fire_s;
  logic                 resp_take_s;
  logic                 buf_pop_s;
  logic [CNT_W:0]       occupancy_s;

  logic [BUS_WIDTH-1:0] pcq_head_s;
  logic [CNT_W-1:0]     pcq_count_s;
  logic                 pcq_full_s;
  logic                 pcq_empty_s;
  logic [ENTRY_W-1:0]   buf_head_s;
  logic [CNT_W-1:0]     buf_count_s;
  logic                 buf_full_s;
  logic                 buf_empty_s;

  // The PC queue count is the number of requests in flight while in RUN.
  fetch_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (fire_s),
    .push_data (pc_r),
    .pop       (resp_take_s),
    .head      (pcq_head_s),
    .count     (pcq_count_s),
    .full      (pcq_full_s),
    .empty     (pcq_empty_s)
  );

  fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(BUF_DEPTH)) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (resp_take_s),
    .push_data ({pcq_head_s, imem_resp_data}),
    .pop       (buf_pop_s),
    .head      (buf_head_s),
    .count     (buf_count_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s)
  );

  fetch_stage_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect_valid),
    .buf_push (resp_take_s),
    .buf_pop  (buf_pop_s),
    .buf_full (buf_full_s),
    .pcq_push (fire_s),
    .pcq_pop  (resp_take_s),
    .pcq_full (pcq_full_s)
  );

  assign occupancy_s   = {1'b0, pcq_count_s} + {1'b0, buf_count_s};
  assign fire_s        = imem_req_valid & imem_req_ready;
  assign resp_take_s   = imem_resp_valid & (state_r == ST_RUN) & ~pcq_empty_s;
  assign outstanding_s = (state_r == ST_RUN) ? pcq_count_s : drop_cnt_r;
  assign imem_req_addr = pc_r;

  // FSM state and discard counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_RUN;
      drop_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      drop_cnt_r <= drop_next_s;
    end
  end

  // FSM next state: a redirect re-arms the discard count from whatever is
  // still outstanding, net of a response that lands in the same cycle.
  always_comb begin
    state_next_s = state_r;
    drop_next_s  = drop_cnt_r;
    if (redirect_valid) begin
      if (imem_resp_valid && (outstanding_s != CNT_W'(0))) begin
        drop_next_s = outstanding_s - CNT_W'(1);
      end else begin
        drop_next_s = outstanding_s;
      end
      state_next_s = (drop_next_s != CNT_W'(0)) ? ST_DISCARD : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          state_next_s = ST_RUN;
          drop_next_s  = '0;
        end
        ST_DISCARD: begin
          if (drop_cnt_r == CNT_W'(0)) begin
            state_next_s = ST_RUN;
            drop_next_s  = '0;
          end else if (imem_resp_valid) begin
            drop_next_s  = drop_cnt_r - CNT_W'(1);
            state_next_s = (drop_cnt_r == CNT_W'(1)) ? ST_RUN : ST_DISCARD;
          end else begin
            drop_next_s  = drop_cnt_r;
            state_next_s = ST_DISCARD;
          end
        end
        default: begin
          state_next_s = ST_RUN;
          drop_next_s  = '0;
        end
      endcase
    end
  end

  // FSM outputs: request issue, limited so every in-flight word has a buffer slot.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst && (state_r == ST_RUN) && !pc_stall && !redirect_valid &&
        (occupancy_s < OCC_LIMIT)) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // PC register: redirect target (word aligned) beats sequential advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= {redirect_pc[BUS_WIDTH-1:2], 2'b00};
    end else if (fire_s) begin
      pc_r <= pc_r + BUS_WIDTH'(4);
    end
  end

  // Buffer head moves into IF/ID only when nothing higher-priority applies.
  always_comb begin
    buf_pop_s = 1'b0;
    if (!flush && !redirect_valid && !if_id_stall && !buf_empty_s) begin
      buf_pop_s = 1'b1;
    end else begin
      buf_pop_s = 1'b0;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (flush || redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (if_id_stall) begin
      if_id_valid <= if_id_valid;
    end else if (!buf_empty_s) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= buf_head_s[ENTRY_W-1:INSTR_WIDTH];
      if_id_instr <= buf_head_s[INSTR_WIDTH-1:0];
    end else begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_STATS_EN
  // Event counters: IF/ID loads and cycles a valid instruction is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched <= 64'd0;
      stat_stalled <= 64'd0;
    end else begin
      if (buf_pop_s)                  stat_fetched <= stat_fetched + 64'd1;
      if (if_id_stall && if_id_valid) stat_stalled <= stat_stalled + 64'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_stall, if_id_stall, flush, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_STATS_EN
  logic [63:0] stat_fetched, stat_stalled;
`endif

  typedef struct { logic [63:0] pc; logic [31:0] instr; } cap_t;
  cap_t        cap_q[$];
  logic [63:0] fire_q[$];
  logic [63:0] mem_q[$];
  logic [63:0] maddr;
  logic        mem_hold;
  int          n_cmp = 0;
  int          n_fail = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stalled(stat_stalled)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return 32'h5A00_0000 ^ a[31:0];
  endfunction

  // In-order memory: a request accepted at an edge is answered for the next
  // edge unless held; queued answers drain one per cycle.
  always @(posedge clk) begin
    if (!rst) begin
      mem_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      if (!mem_hold && mem_q.size() > 0) begin
        maddr = mem_q.pop_front();
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= word_of(maddr);
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  // One clock: note a request fire, then note an IF/ID load after the edge.
  task automatic tick();
    #1;
    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) fire_q.push_back(imem_req_addr);
    @(posedge clk);
    #1;
    if (rst && !flush && !redirect_valid && !if_id_stall && if_id_valid === 1'b1)
      cap_q.push_back('{if_id_pc, if_id_instr});
    @(negedge clk);
  endtask

  task automatic run_caps(input int n, input string name);
    int budget = 40;
    while (cap_q.size() < n && budget > 0) begin tick(); budget--; end
    n_cmp++;
    if (cap_q.size() < n) begin
      $display("FAIL %s_timeout: got %0d loads, required %0d", name, cap_q.size(), n);
      n_fail++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; pc_stall = 1'b0; if_id_stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; imem_req_ready = 1'b1; mem_hold = 1'b0;
    tick(); tick();
    cap_q.delete(); fire_q.delete();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_stall = 1'b0; if_id_stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; imem_req_ready = 1'b1; mem_hold = 1'b0;
    @(negedge clk);
    tick(); tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid: got %b required 0", imem_req_valid); n_fail++; end
    n_cmp++; if (if_id_valid !== 1'b0) begin $display("FAIL reset_if_id_valid: got %b required 0", if_id_valid); n_fail++; end
    n_cmp++; if (if_id_pc !== 64'h0) begin $display("FAIL reset_if_id_pc: got %h required 0", if_id_pc); n_fail++; end
    n_cmp++; if (if_id_instr !== NOP) begin $display("FAIL reset_if_id_instr: got %h required %h", if_id_instr, NOP); n_fail++; end
  endtask

  task automatic test_stream();
    do_reset();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      $display("FAIL stream_first_req: got valid %b addr %h required 1 / 0", imem_req_valid, imem_req_addr); n_fail++; end
    tick();
    n_cmp++; if (if_id_valid !== 1'b0) begin $display("FAIL stream_early1: got %b required 0", if_id_valid); n_fail++; end
    tick();
    n_cmp++; if (if_id_valid !== 1'b0) begin $display("FAIL stream_early2: got %b required 0", if_id_valid); n_fail++; end
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== word_of(64'h0)) begin
      $display("FAIL stream_latency: got v%b pc %h instr %h required v1 pc 0 instr %h", if_id_valid, if_id_pc, if_id_instr, word_of(64'h0)); n_fail++; end
    run_caps(6, "stream");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cap_q[i].pc !== 64'(4 * i) || cap_q[i].instr !== word_of(64'(4 * i))) begin
        $display("FAIL stream_load%0d: got pc %h instr %h required pc %h instr %h", i, cap_q[i].pc, cap_q[i].instr, 64'(4 * i), word_of(64'(4 * i))); n_fail++; end
      n_cmp++;
      if (fire_q[i] !== 64'(4 * i)) begin
        $display("FAIL stream_addr%0d: got %h required %h", i, fire_q[i], 64'(4 * i)); n_fail++; end
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
        $display("FAIL ready_hold%0d: got valid %b addr %h required 1 / 0", k, imem_req_valid, imem_req_addr); n_fail++; end
    end
    imem_req_ready = 1'b1;
    tick();
    n_cmp++; if (imem_req_addr !== 64'h4) begin $display("FAIL ready_advance: got %h required 4", imem_req_addr); n_fail++; end
    n_cmp++; if (fire_q.size() !== 1) begin $display("FAIL ready_fires: got %0d required 1", fire_q.size()); n_fail++; end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    if_id_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0) begin
        $display("FAIL stall_hold%0d: got v%b pc %h required v1 pc 0", k, if_id_valid, if_id_pc); n_fail++; end
      n_cmp++; if (imem_req_valid !== 1'b0) begin
        $display("FAIL stall_issue%0d: got %b required 0", k, imem_req_valid); n_fail++; end
    end
    if_id_stall = 1'b0;
    run_caps(6, "stall");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (cap_q[i].pc !== 64'(4 * i) || cap_q[i].instr !== word_of(64'(4 * i))) begin
        $display("FAIL stall_load%0d: got pc %h instr %h required pc %h", i, cap_q[i].pc, cap_q[i].instr, 64'(4 * i)); n_fail++; end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_hold = 1'b1;
    tick(); tick();
    n_cmp++; if (fire_q.size() !== 2 || imem_req_valid !== 1'b0) begin
      $display("FAIL redir_inflight: got fires %0d valid %b required 2 / 0", fire_q.size(), imem_req_valid); n_fail++; end
    redirect_valid = 1'b1; redirect_pc = 64'h1003;
    tick();
    redirect_valid = 1'b0; mem_hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (imem_req_valid !== 1'b0) begin
        $display("FAIL redir_discard%0d: got valid %b required 0", k, imem_req_valid); n_fail++; end
    end
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
      $display("FAIL redir_resume: got valid %b addr %h required 1 / 1000", imem_req_valid, imem_req_addr); n_fail++; end
    n_cmp++; if (if_id_valid !== 1'b0) begin $display("FAIL redir_no_stale: got %b required 0", if_id_valid); n_fail++; end
    run_caps(1, "redir");
    n_cmp++; if (cap_q[0].pc !== 64'h1000 || cap_q[0].instr !== word_of(64'h1000)) begin
      $display("FAIL redir_first_load: got pc %h instr %h required 1000 / %h", cap_q[0].pc, cap_q[0].instr, word_of(64'h1000)); n_fail++; end
  endtask

  task automatic test_flush_wrap();
    do_reset();
    tick(); tick(); tick();
    flush = 1'b1; if_id_stall = 1'b1;
    tick();
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
      $display("FAIL flush_stall: got v%b instr %h required v0 instr %h", if_id_valid, if_id_instr, NOP); n_fail++; end
    flush = 1'b0; if_id_stall = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      $display("FAIL wrap_top: got valid %b addr %h required 1 / fffffffffffffffc", imem_req_valid, imem_req_addr); n_fail++; end
    tick();
    n_cmp++; if (imem_req_addr !== 64'h0) begin $display("FAIL wrap_zero: got %h required 0", imem_req_addr); n_fail++; end
    run_caps(2, "wrap");
    n_cmp++; if (cap_q[0].pc !== 64'hFFFF_FFFF_FFFF_FFFC || cap_q[1].pc !== 64'h0) begin
      $display("FAIL wrap_loads: got %h %h required fffffffffffffffc 0", cap_q[0].pc, cap_q[1].pc); n_fail++; end
  endtask

  task automatic test_reset_discard();
    do_reset();
    mem_hold = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0; mem_hold = 1'b0; rst = 1'b0;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== NOP) begin
      $display("FAIL rstdisc_outputs: got req %b v%b pc %h instr %h required 0 0 0 %h", imem_req_valid, if_id_valid, if_id_pc, if_id_instr, NOP); n_fail++; end
    cap_q.delete(); fire_q.delete();
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      $display("FAIL rstdisc_restart: got valid %b addr %h required 1 / 0", imem_req_valid, imem_req_addr); n_fail++; end
    run_caps(2, "rstdisc");
    n_cmp++; if (cap_q[0].pc !== 64'h0 || cap_q[1].pc !== 64'h4 || cap_q[0].instr !== word_of(64'h0)) begin
      $display("FAIL rstdisc_loads: got %h %h required 0 4", cap_q[0].pc, cap_q[1].pc); n_fail++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_ready_low();
    test_stall();
    test_redirect();
    test_flush_wrap();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule : tb_fetch_stage
